// File: rtl/div_clk_monitor_pkg.sv
// Shared types and helpers for the divided-clock monitor (package div_mon_pkg).
package div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    MEAS   = 2'd2,
    LOCKED = 2'd3
  } mon_state_t;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] div_mon_sat_inc(input logic [31:0] value,
                                                  input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/div_clk_monitor_if.sv
// Status/stimulus bundle between a divider-monitor client and div_clk_monitor.
interface div_clk_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_in;
  logic             enable;
  logic             clr_err;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             err_period;
  logic             err_stuck;

  modport master (
    output div_in, enable, clr_err,
    input  locked, period, high_time, period_valid, err_period, err_stuck
  );

  modport slave (
    input  div_in, enable, clr_err,
    output locked, period, high_time, period_valid, err_period, err_stuck
  );
endinterface

// File: rtl/div_clk_monitor_edge_sync.sv
// Sampler and rising-edge detector for a divider output (module div_edge_sync).
// DIV_MON_SYNC_EN adds a 2-flop synchronizer ahead of the sample register.
module div_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic samp,
  output logic rise
);
  logic src;
  logic prev;

`ifdef DIV_MON_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[0], din};
  end

  assign src = sync[1];
`else
  assign src = din;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      samp <= 1'b0;
      prev <= 1'b0;
    end else begin
      samp <= src;
      prev <= samp;
    end
  end

  assign rise = samp & ~prev;

endmodule

// File: rtl/div_clk_monitor.sv
// Period / high-time checker for a divide-by-N clock with lock and sticky errors.
// Build option: DIV_MON_SYNC_EN (synchronize div_in before edge detection).
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int DIV    = 9,
  parameter int HIGH   = 4,
  parameter int TOL    = 0,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              reset,
  div_clk_monitor_if.slave mon
);
  localparam int                GOOD_W   = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT  = CNT_W'(2 * DIV);
  localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_N);

  function automatic logic in_tol(input logic [CNT_W-1:0] meas, input int target);
    int diff;
    diff = int'(meas) - target;
    return (diff <= TOL) && (diff >= -TOL);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return CNT_W'(div_mon_sat_inc(32'(v), CNT_W));
  endfunction

  logic samp;
  logic rise;

  div_edge_sync u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (mon.div_in),
    .samp  (samp),
    .rise  (rise)
  );

  mon_state_t        state, state_nxt;
  logic [CNT_W-1:0]  per_cnt, per_nxt;
  logic [CNT_W-1:0]  hi_cnt, hi_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt, good_inc;
  logic [CNT_W-1:0]  period_q, period_nxt;
  logic [CNT_W-1:0]  high_q, high_nxt;
  logic              pv_q, pv_nxt;
  logic              errp_q, errs_q, locked_q;
  logic              new_per, new_stuck, good;

  assign good_inc = good_cnt + 1'b1;
  assign good     = in_tol(per_cnt, DIV) && in_tol(hi_cnt, HIGH);

  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt;
    hi_nxt     = hi_cnt;
    good_nxt   = good_cnt;
    period_nxt = period_q;
    high_nxt   = high_q;
    pv_nxt     = 1'b0;
    new_per    = 1'b0;
    new_stuck  = 1'b0;

    if (!mon.enable) begin
      state_nxt = IDLE;
      per_nxt   = '0;
      hi_nxt    = '0;
      good_nxt  = '0;
    end else if (state == IDLE) begin
      state_nxt = ACQ;
    end else begin
      per_nxt = sat_inc(per_cnt);
      hi_nxt  = samp ? sat_inc(hi_cnt) : hi_cnt;
      if (rise) begin
        // Edge cycle counts as the first cycle (and first high sample) of the next period.
        per_nxt = CNT_W'(1);
        hi_nxt  = CNT_W'(1);
        if (state == ACQ) begin
          state_nxt = MEAS;
        end else begin
          pv_nxt     = 1'b1;
          period_nxt = per_cnt;
          high_nxt   = hi_cnt;
          if (!good) begin
            new_per   = 1'b1;
            good_nxt  = '0;
            state_nxt = MEAS;
          end else if (state == MEAS) begin
            good_nxt = good_inc;
            if (good_inc >= LOCK_CNT) state_nxt = LOCKED;
          end
        end
      end else if (per_cnt == TIMEOUT) begin
        new_stuck = 1'b1;
        per_nxt   = '0;
        good_nxt  = '0;
        state_nxt = ACQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      good_cnt <= '0;
      period_q <= '0;
      high_q   <= '0;
      pv_q     <= 1'b0;
      errp_q   <= 1'b0;
      errs_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      per_cnt  <= per_nxt;
      hi_cnt   <= hi_nxt;
      good_cnt <= good_nxt;
      period_q <= period_nxt;
      high_q   <= high_nxt;
      pv_q     <= pv_nxt;
      // A fresh error beats a simultaneous clear.
      errp_q   <= new_per   | (errp_q & ~mon.clr_err);
      errs_q   <= new_stuck | (errs_q & ~mon.clr_err);
      locked_q <= (state_nxt == LOCKED);
    end
  end

  assign mon.locked       = locked_q;
  assign mon.period       = period_q;
  assign mon.high_time    = high_q;
  assign mon.period_valid = pv_q;
  assign mon.err_period   = errp_q;
  assign mon.err_stuck    = errs_q;

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Downstream checker for the divided clock produced by the divide-by-N stage. It samples the divider output in the `clk` domain, detects rising edges, and measures the period and high time of each cycle in `clk` cycles. It then declares lock after a run of in-tolerance cycles and raises sticky errors on bad or missing edges. It sits beside the divider in the clock-generation block and feeds status to the control/register layer.

## Interface
- `DIV`, 9: expected period in `clk` cycles.
- `HIGH`, 4: expected high time, counted in sampled `clk` cycles.
- `TOL`, 0: allowed absolute deviation on period and on high time.
- `LOCK_N`, 4: consecutive good measurements required for lock.
- `CNT_W`, 8: width of the period and high-time counters and outputs.

Ports:
- `clk`  in  1  system clock; drives the divider and this block.
- `reset`  in  1  synchronous, active-low.
- `div_in`  in  1  divider output under test.
- `enable`  in  1  monitor enable.
- `clr_err`  in  1  clears both sticky error flags.
- `locked`  out  1  lock status.
- `period`  out  CNT_W  last measured period.
- `high_time`  out  CNT_W  last measured high time.
- `period_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `err_period`  out  1  sticky; an out-of-tolerance cycle occurred.
- `err_stuck`  out  1  sticky; no rising edge seen within `2*DIV` cycles.

## Operation
- **Reset** (`reset`=0 at a `clk` edge) forces:
  - all outputs to 0;
  - counters to 0;
  - `good_cnt` to 0;
  - state to IDLE.
- **Edge detect:** `rise` = sampled `div_in` is 1 and the previous sample is 0.
- **Counters:**
  - `per_cnt` increments every cycle in ACQ, MEAS and LOCKED.
  - `hi_cnt` increments in cycles where the sampled `div_in` is 1.
  - Both saturate at `2^CNT_W-1`; they never wrap.
  - On `rise`, `per_cnt` loads 1, and `hi_cnt` loads 1 (the edge cycle is sampled high).
- **Measurement:** On `rise` in MEAS or LOCKED:
  - `period` takes `per_cnt` and `high_time` takes `hi_cnt`, both values from before the reload;
  - `period_valid` pulses;
  - the cycle is good iff |`period`−`DIV`| ≤ `TOL` and |`high_time`−`HIGH`| ≤ `TOL`.
- **States:**
  - IDLE: `enable`=0. Counters are held at 0. Moves to ACQ when `enable`=1.
  - ACQ: wait for the first `rise` and make no measurement. On `rise`, go to MEAS. If `per_cnt` reaches `2*DIV`, set `err_stuck`, reload `per_cnt` to 0 and stay in ACQ.
  - MEAS: a good cycle increments `good_cnt`. A bad cycle clears `good_cnt` and sets `err_period`. When `good_cnt` reaches `LOCK_N`, go to LOCKED.
  - LOCKED: `locked`=1. A bad cycle sets `err_period`, clears `good_cnt` and goes to MEAS.
  - Timeout in MEAS or LOCKED: when `per_cnt` reaches `2*DIV`, set `err_stuck`, clear `good_cnt` and go to ACQ.
  - From any state, `enable`=0 goes to IDLE. `locked` clears and the sticky errors are retained.
- **Sticky errors:** `clr_err` clears both flags. If a new error is raised in the same cycle as `clr_err`, the error wins and the flag reads 1.
- **Mid-operation reset:** `reset` overrides everything, including the sticky flags.

## Timing
- All outputs are registered and update on the `clk` edge after the decision cycle.
- Latency from `div_in` rising (as sampled) to `period_valid`:
  - 3 cycles with the synchronizer;
  - 1 cycle without it.
- `locked` rises in the cycle with the `LOCK_N`-th good `period_valid`.
- `locked` falls one cycle after a bad measurement, a timeout or `enable`=0.
- `period_valid` is never asserted in IDLE or ACQ.

## Configuration
- `DIV_MON_SYNC_EN` defined: `div_in` passes through a 2-flop synchronizer before the edge register. Use this when the divider output is asynchronous or glitchy relative to `clk`.
- Undefined: `div_in` is registered once and feeds edge detection directly, removing 2 cycles of latency. Measured values are identical.

## Structure
- Package `div_mon_pkg`:
  - state enum (IDLE, ACQ, MEAS, LOCKED);
  - a `div_mon_sat_inc` counter-width helper constant or function.
- Sub-module `div_edge_sync` contains the optional synchronizer, the sample register and `rise` generation. It is reusable for other divider outputs.

## Test plan
All scenarios use default parameters.
1. **Ideal lock.** Drive `div_in` high 4 cycles, low 5 cycles, repeating, with `enable`=1.
   - First `rise`: no pulse.
   - Each later `rise`: `period_valid` with `period`=9 and `high_time`=4.
   - `locked`=1 at the 4th pulse.
   - Both error flags stay 0.
2. **Bad period.** While locked, insert one cycle of 10.
   - `period`=10, `err_period`=1, `locked`=0 the next cycle.
   - Relock after 4 further good cycles.
3. **Stuck input.** Hold `div_in` low after a `rise` in LOCKED.
   - `err_stuck`=1 and `locked`=0 at `per_cnt`=18; state returns to ACQ.
   - Resuming the waveform relocks after 5 rises.
4. **Clear race.** Assert `clr_err` in the same cycle as a bad measurement, then `clr_err` alone.
   - First: `err_period` stays 1.
   - Then: it reads 0.
5. **Disable.** Drop `enable` while locked.
   - `locked`=0 and `period_valid` silent.
   - Sticky flags are unchanged.
   - Re-enabling needs a fresh ACQ.
6. **Mid-operation reset.** Assert `reset`=0 during MEAS.
   - All outputs read 0 the next cycle.
   - Repeat scenario 1 with and without `DIV_MON_SYNC_EN`: pulse timing shifts by 2 cycles and values match.
